// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and single-port memory side.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_addr, mem_wdata, mem_we
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory; one access per two cycles.
// Define ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state;
   logic   win_data;
   logic   pick_data;
   logic   any_req;

   assign any_req = bus.if_req | bus.d_req;

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;

   always_comb begin
      pick_data = bus.d_req && !(bus.if_req && (starve_cnt == 4'(STARVE_LIMIT)));
   end

   // Counter only moves on arbitration cycles; it cannot pass STARVE_LIMIT
   // because fetch wins as soon as the limit is reached.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state != ACCESS) begin
         if (bus.if_req && pick_data)
            starve_cnt <= starve_cnt + 4'd1;
         else
            starve_cnt <= '0;
      end
   end
`else
   always_comb begin
      pick_data = bus.d_req;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         win_data      <= 1'b0;
         bus.if_gnt    <= 1'b0;
         bus.d_gnt     <= 1'b0;
         bus.if_rvalid <= 1'b0;
         bus.d_rvalid  <= 1'b0;
         bus.if_rdata  <= '0;
         bus.d_rdata   <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_we    <= 1'b0;
      end else begin
         case (state)
            IDLE, RESP: begin
               bus.if_rvalid <= 1'b0;
               bus.d_rvalid  <= 1'b0;
               if (any_req) begin
                  win_data      <= pick_data;
                  bus.if_gnt    <= ~pick_data;
                  bus.d_gnt     <= pick_data;
                  bus.mem_addr  <= pick_data ? bus.d_addr : bus.if_addr;
                  bus.mem_wdata <= pick_data ? bus.d_wdata : '0;
                  bus.mem_we    <= pick_data & bus.d_we;
                  state         <= ACCESS;
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               bus.if_gnt <= 1'b0;
               bus.d_gnt  <= 1'b0;
               bus.mem_we <= 1'b0;
               // Writes capture too: d_rdata returns the pre-write contents.
               if (win_data) begin
                  bus.d_rdata  <= bus.mem_rdata;
                  bus.d_rvalid <= 1'b1;
               end else begin
                  bus.if_rdata  <= bus.mem_rdata;
                  bus.if_rvalid <= 1'b1;
               end
               state <= RESP;
            end
            default: begin
               bus.if_gnt <= 1'b0;
               bus.d_gnt  <= 1'b0;
               bus.mem_we <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
